// File: rtl/fpu_issue_ctrl.sv
// Multi-cycle FPU issue controller: stalls the PC while a long-latency FP op is in
// flight, releases a single gated FP write cycle, and counts stall cycles.
module fpu_issue_ctrl #(
   parameter int ADD_LAT = 3,
   parameter int MUL_LAT = 4,
   parameter int DIV_LAT = 12
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        fp_start,
   input  logic [3:0]  fpucontrol,
   input  logic        fp_regwrite_req,
   output logic        stall,
   output logic        fp_regwrite,
   output logic        fpu_busy,
   output logic [31:0] stall_count
);

   typedef enum logic [1:0] {IDLE, BUSY, WB} state_t;

   state_t     state, state_nxt;
   logic [4:0] count, count_nxt;
   logic [4:0] lat_cur;

   function automatic logic [4:0] op_lat(input logic [3:0] op);
      case (op)
         4'b0000, 4'b0001: return 5'(ADD_LAT);
         4'b0010:          return 5'(MUL_LAT);
         4'b0011:          return 5'(DIV_LAT);
         default:          return 5'd1;
      endcase
   endfunction

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   assign lat_cur = op_lat(fpucontrol);

   always_comb begin
      state_nxt   = state;
      count_nxt   = count;
      stall       = 1'b0;
      fp_regwrite = 1'b0;
      fpu_busy    = 1'b0;
      case (state)
         IDLE: begin
            if (fp_start && (lat_cur >= 5'd2)) begin
               stall     = 1'b1;
               count_nxt = lat_cur - 5'd2;
               state_nxt = BUSY;
            end else begin
               fp_regwrite = fp_regwrite_req;
            end
         end
         BUSY: begin
            stall    = 1'b1;
            fpu_busy = 1'b1;
            // Decide on count==0 before decrementing so count never wraps.
            if (count == 5'd0) state_nxt = WB;
            else               count_nxt = count - 5'd1;
         end
         WB: begin
            // A reset landing on the retire cycle abandons the op without a write.
            fp_regwrite = fp_regwrite_req & ~reset;
            state_nxt   = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         count       <= 5'd0;
         stall_count <= 32'd0;
      end else begin
         state <= state_nxt;
         count <= count_nxt;
         if (stall) stall_count <= sat_inc(stall_count);
      end
   end

endmodule
